// File: rtl/alu_operand_collector.sv
// ALU input stage: pairs operands arriving over one or two beats and issues them with a
// one-cycle OP_VALID strobe, or ERR on a missing-operand timeout or operand mismatch.
module alu_operand_collector #(
    parameter int unsigned N       = 8,
    parameter int unsigned M       = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CE,
    input  logic [1:0]   INP_VALID,
    input  logic         MODE,
    input  logic [M-1:0] CMD,
    input  logic         CIN,
    input  logic [N-1:0] OPA,
    input  logic [N-1:0] OPB,
    output logic         OP_VALID,
    output logic [N-1:0] OPA_Q,
    output logic [N-1:0] OPB_Q,
    output logic [M-1:0] CMD_Q,
    output logic         MODE_Q,
    output logic         CIN_Q,
    output logic         ERR,
    output logic         BUSY
);

    typedef enum logic [1:0] {StIdle, StWaitA, StWaitB} state_e;

    // Counter value seen on the last permitted wait cycle.
    localparam logic [4:0] LastWait = 5'(TIMEOUT - 1);

    state_e         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [N-1:0]   opa_d, opb_d;
    logic [M-1:0]   cmd_d;
    logic           mode_d, cin_d, op_valid_d, err_d;
    logic           a_only, b_only;

    always_comb begin
        a_only = 1'b0;
        b_only = 1'b0;
        if (MODE) begin
            a_only = (CMD == M'(4)) || (CMD == M'(5));
            b_only = (CMD == M'(6)) || (CMD == M'(7));
        end else begin
            a_only = (CMD == M'(6)) || (CMD == M'(8)) || (CMD == M'(9));
            b_only = (CMD == M'(7)) || (CMD == M'(10)) || (CMD == M'(11));
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opa_d      = OPA_Q;
        opb_d      = OPB_Q;
        cmd_d      = CMD_Q;
        mode_d     = MODE_Q;
        cin_d      = CIN_Q;
        op_valid_d = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            StIdle: begin
                case (INP_VALID)
                    2'b11: begin
                        opa_d      = OPA;
                        opb_d      = OPB;
                        cmd_d      = CMD;
                        mode_d     = MODE;
                        cin_d      = CIN;
                        op_valid_d = 1'b1;
                    end
                    2'b01: begin
                        if (b_only) begin
                            err_d = 1'b1;
                        end else begin
                            opa_d  = OPA;
                            cmd_d  = CMD;
                            mode_d = MODE;
                            cin_d  = CIN;
                            if (a_only) begin
                                op_valid_d = 1'b1;
                            end else begin
                                state_d = StWaitB;
                                cnt_d   = '0;
                            end
                        end
                    end
                    2'b10: begin
                        if (a_only) begin
                            err_d = 1'b1;
                        end else begin
                            opb_d  = OPB;
                            cmd_d  = CMD;
                            mode_d = MODE;
                            cin_d  = CIN;
                            if (b_only) begin
                                op_valid_d = 1'b1;
                            end else begin
                                state_d = StWaitA;
                                cnt_d   = '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            StWaitB: begin
                if (INP_VALID[1]) begin
                    opb_d      = OPB;
                    op_valid_d = 1'b1;
                    state_d    = StIdle;
                end else if (cnt_q == LastWait) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StWaitA: begin
                if (INP_VALID[0]) begin
                    opa_d      = OPA;
                    op_valid_d = 1'b1;
                    state_d    = StIdle;
                end else if (cnt_q == LastWait) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            OPA_Q    <= '0;
            OPB_Q    <= '0;
            CMD_Q    <= '0;
            MODE_Q   <= 1'b0;
            CIN_Q    <= 1'b0;
            OP_VALID <= 1'b0;
            ERR      <= 1'b0;
            BUSY     <= 1'b0;
        end else if (CE) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            OPA_Q    <= opa_d;
            OPB_Q    <= opb_d;
            CMD_Q    <= cmd_d;
            MODE_Q   <= mode_d;
            CIN_Q    <= cin_d;
            OP_VALID <= op_valid_d;
            ERR      <= err_d;
            BUSY     <= (state_d != StIdle);
        end
    end

endmodule

// File: doc/alu_operand_collector.md
Name: alu_operand_collector

Overview:
- Responder-side input stage of the ALU.
- Accepts the driver's operand stream (INP_VALID, CE, CMD, MODE, CIN, OPA, OPB), assembles a complete operand set across one or two beats, and presents it to the ALU datapath with a one-cycle OP_VALID strobe.
- Enforces the 16-cycle operand-pairing timeout and raises ERR when the missing operand never arrives.

Parameters:
N, 8, operand width
M, 4, CMD width
TIMEOUT, 16, CE-enabled wait cycles allowed for the second operand (legal range 2..31)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
CE  input  1  clock enable; all state and outputs hold when low
INP_VALID  input  2  bit0 = OPA valid, bit1 = OPB valid
MODE  input  1  1 = arithmetic, 0 = logical
CMD  input  M  operation code
CIN  input  1  carry in
OPA  input  N  operand A
OPB  input  N  operand B
OP_VALID  output  1  complete operand set presented (one CE-enabled cycle)
OPA_Q  output  N  captured operand A
OPB_Q  output  N  captured operand B
CMD_Q  output  M  captured command
MODE_Q  output  1  captured mode
CIN_Q  output  1  captured carry in
ERR  output  1  timeout or operand mismatch (one CE-enabled cycle)
BUSY  output  1  high while in WAIT_A or WAIT_B

Behaviour:
- Reset (async, RST=1): state IDLE, wait counter 0, all outputs 0. Reset mid-wait discards the partial operand; no ERR is issued.
- CE=0: FSM, counter and every output register hold their values.
- All outputs are registered. OP_VALID and ERR assert the cycle after the deciding beat. Each stays high for exactly one CE=1 cycle.

Operand need decode (from MODE/CMD at the first beat):
- A-only:
  - MODE=1: CMD 4, 5
  - MODE=0: CMD 6, 8, 9
- B-only:
  - MODE=1: CMD 6, 7
  - MODE=0: CMD 7, 10, 11
- Two-operand: every other CMD value.

FSM states: IDLE, WAIT_A, WAIT_B.

IDLE, CE=1:
- INP_VALID=11: capture OPA, OPB, CMD, MODE, CIN; issue.
- INP_VALID=01:
  - A-only command: capture and issue.
  - Two-operand command: capture OPA, CMD, MODE, CIN; counter=0; go to WAIT_B.
  - B-only command: ERR pulse; stay in IDLE.
- INP_VALID=10: symmetric to 01 (B-only issues; two-operand goes to WAIT_A; A-only gives ERR).
- INP_VALID=00: no action.

WAIT_B, CE=1:
- INP_VALID bit1=1: capture OPB only; issue; go to IDLE.
  - If INP_VALID=11, the new OPA is ignored and the first-beat OPA is kept.
  - CMD, MODE and CIN on later beats are ignored.
- Otherwise: counter+1. When the counter reaches TIMEOUT with no OPB, assert ERR, drop the partial set (no OP_VALID) and return to IDLE.

WAIT_A, CE=1: mirror of WAIT_B (waits on bit0, captures OPA only).

Timing and widths:
- With TIMEOUT=16, ERR rises on the edge after the 16th CE-enabled wait cycle that follows the first-beat cycle.
- Arrival on the 16th wait cycle is still accepted.
- CE=0 cycles do not count toward the timeout.
- Counter width is 5 bits. It resets to 0 on every entry to a wait state.

Output hold rules:
- OPA_Q, OPB_Q, CMD_Q, MODE_Q and CIN_Q change only on capture and hold between transactions.
- The operand not used by a single-operand command keeps its previous value.
- BUSY is registered with the state.

Test Plan:
- After reset: CE=1, MODE=1, CMD=0, INP_VALID=11, OPA=8'h12, OPB=8'h34 -> next cycle OP_VALID=1, OPA_Q=12, OPB_Q=34, CMD_Q=0, ERR=0, BUSY=0.
- Split beats: MODE=1, CMD=0, INP_VALID=01, OPA=8'hA5; 5 cycles INP_VALID=00; then INP_VALID=10, OPB=8'h0F -> BUSY=1 during the wait; OP_VALID one cycle after the OPB beat with OPA_Q=A5, OPB_Q=0F; BUSY=0.
- Timeout: MODE=0, CMD=1, INP_VALID=10; 16 cycles INP_VALID=00 with CE=1 -> ERR=1 on the 17th edge for one cycle; OP_VALID stays 0; state IDLE. The same stimulus with OPB... replaced by INP_VALID=01 on wait cycle 16 -> OP_VALID=1, ERR=0.
- CE freeze: enter WAIT_B, 4 wait cycles, CE=0 for 10 cycles, CE=1 -> all outputs stable during CE=0; ERR only after 12 further wait cycles (16 total).
- Single-operand and mismatch: MODE=1, CMD=4, INP_VALID=01, OPA=8'hFF -> OP_VALID next cycle, no wait state. MODE=1, CMD=6, INP_VALID=01 -> ERR=1 one cycle, OP_VALID=0.
- Async reset mid-wait: RST asserted between edges while in WAIT_A -> outputs 0 immediately; after release, a fresh INP_VALID=11 beat completes normally with no ERR.
